// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - Two-read / one-write flip-flop register file with byte enables
//
// Purpose:
//   DEPTH x WIDTH register file built from flops. It has two independent
//   combinational read ports and one write port with byte enables. There is
//   also a synchronous clear and an asynchronous active-low reset.
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   When REGFILE_BYPASS_EN is defined, each read port forwards the write in
//   flight. If the read address matches a valid write, the port returns the
//   merged word before the clock edge. If clr is high, the port returns zero.
//   When the macro is undefined, no forwarding logic is built and the ports
//   read storage only.
//
// Parameters:
//   WIDTH    - data bits per entry; must be a multiple of 8
//   DEPTH    - number of entries, 2..256
//   ZERO_REG - 1: entry 0 is hard-wired to zero and ignores writes
//
// Ports:
//   clk        in   clock; all state changes on the rising edge
//   reset_n    in   asynchronous active-low reset; clears all entries
//   clr        in   synchronous clear of all entries; has priority over we
//   we         in   write enable
//   wr_addr    in   [AW-1:0]      write address
//   wr_be      in   [WIDTH/8-1:0] byte enables; bit k covers bits 8k+7..8k
//   wr_data    in   [WIDTH-1:0]   write data
//   rd_addr0   in   [AW-1:0]      read address, port 0
//   rd_addr1   in   [AW-1:0]      read address, port 1
//   rd_data0   out  [WIDTH-1:0]   read data, port 0 (combinational)
//   rd_data1   out  [WIDTH-1:0]   read data, port 1 (combinational)

module regfile_2r1w #(
  parameter int  WIDTH    = 32,
  parameter int  DEPTH    = 8,
  parameter int  ZERO_REG = 0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               we,
  input  logic [AW-1:0]      wr_addr,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [AW-1:0]      rd_addr0,
  input  logic [AW-1:0]      rd_addr1,
  output logic [WIDTH-1:0]   rd_data0,
  output logic [WIDTH-1:0]   rd_data1
);

  localparam int          NB      = WIDTH / 8;
  // One extra bit so that DEPTH itself fits when DEPTH is a power of two.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic             wr_in_range;
  logic             wr_valid;
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_merged;
  logic [WIDTH-1:0] rd_raw0;
  logic [WIDTH-1:0] rd_raw1;

  // An address is usable when it is inside the array. With ZERO_REG set,
  // address 0 is not usable.
  function automatic logic addr_in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W);
  endfunction

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return addr_in_range(a) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // ---------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------
  always_comb begin
    wr_in_range = addr_in_range(wr_addr);
    wr_valid    = we && !clr && addr_ok(wr_addr);
  end

  // The out-of-range guard keeps the index inside the array when DEPTH is
  // not a power of two. The merged value is not used in that case.
  always_comb begin
    wr_old = '0;
    if (wr_in_range) begin
      wr_old = mem_q[wr_addr];
    end
  end

  // Enabled bytes come from wr_data; the other bytes keep the stored value.
  // The forwarding path reuses this same word, so a forwarded read matches
  // what the entry will hold after the edge.
  always_comb begin
    wr_merged = wr_old;
    for (int k = 0; k < NB; k++) begin
      if (wr_be[k]) begin
        wr_merged[8*k +: 8] = wr_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
    end else if (wr_valid) begin
      mem_d[wr_addr] = wr_merged;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  always_comb begin
    rd_raw0 = '0;
    if (addr_ok(rd_addr0)) begin
      rd_raw0 = mem_q[rd_addr0];
    end
  end

  always_comb begin
    rd_raw1 = '0;
    if (addr_ok(rd_addr1)) begin
      rd_raw1 = mem_q[rd_addr1];
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding only applies to usable addresses. Out-of-range addresses
  // and the zero register still read 0, so the bypass is gated by addr_ok.
  // The outputs are also forced to 0 during reset, because an incoming
  // write would otherwise leak through the bypass.
  always_comb begin
    rd_data0 = '0;
    if (reset_n && addr_ok(rd_addr0)) begin
      if (clr) begin
        rd_data0 = '0;
      end else if (wr_valid && (rd_addr0 == wr_addr)) begin
        rd_data0 = wr_merged;
      end else begin
        rd_data0 = rd_raw0;
      end
    end
  end

  always_comb begin
    rd_data1 = '0;
    if (reset_n && addr_ok(rd_addr1)) begin
      if (clr) begin
        rd_data1 = '0;
      end else if (wr_valid && (rd_addr1 == wr_addr)) begin
        rd_data1 = wr_merged;
      end else begin
        rd_data1 = rd_raw1;
      end
    end
  end
`else
  // Storage is already zero while reset is held. The reset_n gate only
  // keeps the outputs explicitly zero during reset, which matches the
  // bypass build.
  always_comb begin
    rd_data0 = '0;
    if (reset_n) begin
      rd_data0 = rd_raw0;
    end
  end

  always_comb begin
    rd_data1 = '0;
    if (reset_n) begin
      rd_data1 = rd_raw1;
    end
  end
`endif

endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per entry; must be a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 8, number of entries, range 2..256.
REQ-003 SHALL have parameter ZERO_REG, default 0; when 1, entry 0 always reads zero and ignores writes.
REQ-004 SHALL derive AW = ceil(log2(DEPTH)) internally; it is not user-settable.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 clr  input  1  synchronous clear of all entries.
REQ-008 we  input  1  write enable.
REQ-009 wr_addr  input  AW  write address.
REQ-010 wr_be  input  WIDTH/8  byte enables; bit k covers data bits 8k+7..8k.
REQ-011 wr_data  input  WIDTH  write data.
REQ-012 rd_addr0, rd_addr1  input  AW each  read addresses, ports 0 and 1.
REQ-013 rd_data0, rd_data1  output  WIDTH each  read data, ports 0 and 1.

Function
REQ-014 Storage SHALL be DEPTH x WIDTH flip-flops; reads SHALL be combinational from storage, with zero cycles of latency.
REQ-015 On a rising edge with we=1, clr=0, and wr_addr < DEPTH, bytes with wr_be[k]=1 SHALL take wr_data; other bytes hold.
REQ-016 A write with wr_be all zero SHALL leave storage unchanged.
REQ-017 A write with wr_addr >= DEPTH (non-power-of-2 DEPTH) SHALL be ignored.
REQ-018 A read with address >= DEPTH SHALL return 0.
REQ-019 With ZERO_REG=1, writes to address 0 SHALL be ignored, and reads of address 0 SHALL return 0 on both ports, with or without bypass.
REQ-020 On a rising edge with clr=1, every entry SHALL become 0; clr SHALL take priority over a simultaneous we.
REQ-021 Both read ports SHALL be fully independent, including when both read the same address.
REQ-022 Without bypass, a read of the address being written SHALL return the old value until the edge, and the new value afterwards.

Reset
REQ-023 While reset_n=0, every entry SHALL be 0 immediately, without waiting for clk.
REQ-024 While reset_n=0, rd_data0 and rd_data1 SHALL be 0, and we and clr SHALL have no effect.
REQ-025 Reset asserted in the same cycle as a write SHALL leave the entry at 0 after reset_n is released.
REQ-026 The first write SHALL take effect on the first rising edge after reset_n rises.

Configuration
REQ-027 The macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-028 With REGFILE_BYPASS_EN defined, a read port whose address equals wr_addr while we=1 (valid, not suppressed by ZERO_REG) SHALL combinationally return the merged value: enabled bytes from wr_data, the rest from storage.
REQ-029 With REGFILE_BYPASS_EN defined, a read port SHALL return 0 whenever clr=1, matching the post-edge state.
REQ-030 With REGFILE_BYPASS_EN undefined, REQ-022 SHALL hold and the design SHALL contain no forwarding logic.
REQ-031 The write and storage behaviour SHALL be identical in both builds.

Verification
REQ-032 Reset: hold reset_n=0 and write 32'h1111_1010 to address 3, then release reset_n -> rd_data0 of address 3 reads 32'h0000_0000.
REQ-033 Byte-enable write: write 32'hFFFF_FFFF to address 2, then write 32'h1100_0011 with wr_be=4'b0101 -> address 2 reads 32'hFF00_FF11.
REQ-034 Dual read: address 1 holds 32'h1010_0101 and address 5 holds 32'h1110_0111; read rd_addr0=1 and rd_addr1=5 -> rd_data0=32'h1010_0101 and rd_data1=32'h1110_0111 in the same cycle.
REQ-035 Clear beats write: with clr=1, we=1, and 32'h1000_0000 to address 4 on one edge -> all entries read 0 after that edge.
REQ-036 Bypass: write 32'h0000_0101 to address 6, which held 32'h1011_1111, with rd_addr0=6 -> before the edge, 32'h0000_0101 with REGFILE_BYPASS_EN and 32'h1011_1111 without it.
REQ-037 ZERO_REG=1 with DEPTH=6: write 32'hDEAD_BEEF to address 0 and to address 7 -> reads of address 0 and address 7 both return 0, and no other entry changes.
